store_data_aligner: RTL
=======================

# store_data_aligner

Store-path counterpart to the load-side sign extender. It accepts a store request from the MIPS execute/memory stage: a 32-bit register value, an access size and a byte address. It replicates the narrow datum across byte lanes, generates byte enables, and drives a word-aligned write request to data memory under a req/ack handshake. Misaligned or reserved-size stores and memory timeouts are reported as a one-cycle error pulse instead of a write.

## Interface

Parameters:
- ADDR_W, 32: byte-address width.
- TIMEOUT, 255: maximum cycles to wait for mem_ack before aborting. 0 disables the timeout. Must fit in 16 bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  block can accept a request; combinational, equals (state == IDLE).
- st_addr  in  ADDR_W  store byte address.
- st_size  in  2  access size: 00 byte (SB), 01 half (SH), 10 word (SW), 11 reserved.
- st_data  in  32  store source register value; only low bits are used for byte and half.
- st_done  out  1  one-cycle pulse when memory has acknowledged the write.
- st_err  out  1  one-cycle pulse on misalignment, reserved size, or timeout.
- mem_req  out  1  write request to data memory.
- mem_addr  out  ADDR_W  word address: {st_addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables; bit i enables mem_wdata[8i+7:8i].
- mem_ack  in  1  memory accepted the write.

## Operation

- FSM states: IDLE and REQ.
- In IDLE, st_ready=1. A request is accepted on a rising edge where st_valid=1.
- Fault check on acceptance. The request is faulty if any of these hold:
  - st_size=11;
  - st_size=01 and st_addr[0]=1;
  - st_size=10 and st_addr[1:0]≠00.
- Faulty request: st_err=1 for the next cycle only. No memory request is made, the state stays IDLE, and mem_* are unchanged.
- Valid request: capture mem_addr, mem_wdata and mem_be, set mem_req=1, clear the timeout counter, and go to REQ.
- Lane rules (little-endian lane numbering, addr[1:0] selects the lane):
  - byte: wdata={4{st_data[7:0]}}, be=4'b0001<<st_addr[1:0];
  - half: wdata={2{st_data[15:0]}}, be=st_addr[1]?4'b1100:4'b0011;
  - word: wdata=st_data, be=4'b1111.
- In REQ:
  - st_ready=0, and mem_addr, mem_wdata, mem_be and mem_req are held stable.
  - The counter increments every cycle without mem_ack.
- mem_ack=1 sampled in REQ:
  - mem_req and mem_be go to 0;
  - st_done=1 for the next cycle;
  - state returns to IDLE.
- Timeout (TIMEOUT≠0): if the counter reaches TIMEOUT-1 with mem_ack=0, the request is aborted on that edge.
  - mem_req and mem_be go to 0, st_err pulses, and state returns to IDLE.
  - If mem_ack=1 arrives on that same edge, ack wins and the result is st_done, not st_err.
- mem_ack in IDLE is ignored.
- st_valid in REQ is ignored; the requester must hold the request until st_ready is 1.
- mem_be=0 whenever mem_req=0. mem_addr and mem_wdata keep their last value when idle.

## Timing

- Reset (asynchronous, takes effect immediately): state=IDLE, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, st_done=0, st_err=0, counter=0.
- Reset during REQ drops mem_req at once. The store is lost and no st_done is issued.
- Request accepted at edge N → mem_req high from the cycle after N.
- Ack sampled at edge M → st_done high and st_ready high in the cycle after M, with mem_req low in that same cycle.
- A new request can be accepted at edge M+1. Minimum store period is 2 cycles with zero-wait memory, where ack is high in the first mem_req cycle.
- Fault reject → st_err high the cycle after acceptance. st_ready stays 1, so a new request can be accepted on the very next edge.
- Timeout → mem_req high for exactly TIMEOUT cycles, then st_err for 1 cycle.
- st_done and st_err are never high together.

## Test plan

- SB at 0x1003 with data 0xDEADBEEF, ack held high → mem_addr=0x1000, mem_wdata=0xEFEFEFEF, mem_be=1000, mem_req for 1 cycle, then st_done pulse.
- SH at 0x2002 with data 0x1234ABCD, ack delayed 3 cycles → wdata=0xABCDABCD, be=1100, mem_req stable for 4 cycles, st_ready=0 throughout, then a single st_done.
- SW at 0x3001, and SH at 0x3001, and st_size=11 → each gives an st_err pulse the next cycle; mem_req never rises and mem_be stays 0.
- TIMEOUT=4 with mem_ack tied low → mem_req high for 4 cycles, st_err pulse, back to IDLE. Repeat with ack arriving on the 4th cycle → st_done, no st_err.
- Back-to-back SW 0x0/0xAAAAAAAA then SB 0x5/0x11, with ack always high → two requests 2 cycles apart; the second has be=0010 and wdata=0x11111111.
- rst_n asserted mid-REQ → mem_req, mem_be, st_done and st_err are 0 immediately. After release st_ready=1 and a subsequent store completes normally.

Source files
------------

// File: rtl/store_data_aligner.sv
// rtl/store_data_aligner.sv - store-path lane replicator and memory write requester
//
// Accepts a MIPS store (register value, size, byte address), replicates the
// datum across byte lanes, builds byte enables, and issues a word-aligned
// write to data memory under a req/ack handshake. Misaligned/reserved stores
// and memory timeouts produce a one-cycle st_err pulse instead of a write.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   st_valid/st_ready store request handshake (ready == IDLE)
//   st_addr, st_size  byte address, size (00 byte, 01 half, 10 word, 11 rsvd)
//   st_data           store source value
//   st_done, st_err   one-cycle completion / error pulses
//   mem_req, mem_ack  memory write handshake
//   mem_addr          word address
//   mem_wdata, mem_be lane-replicated data and byte enables
module store_data_aligner #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [1:0]        st_size,
  input  logic [31:0]       st_data,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack
);

  typedef enum logic {IDLE, REQ} state_t;

  // Counter value at which an unacknowledged request is abandoned; with
  // TIMEOUT=0 this constant is never used because the check is disabled.
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        fault;
  logic [31:0] lane_data;
  logic [3:0]  lane_be;
  logic        timeout_hit;

  assign st_ready = (state == IDLE);

  always_comb begin
    fault     = 1'b0;
    lane_data = st_data;
    lane_be   = 4'b1111;
    case (st_size)
      2'b00: begin
        lane_data = {4{st_data[7:0]}};
        lane_be   = 4'b0001 << st_addr[1:0];
      end
      2'b01: begin
        lane_data = {2{st_data[15:0]}};
        lane_be   = st_addr[1] ? 4'b1100 : 4'b0011;
        fault     = st_addr[0];
      end
      2'b10: begin
        fault = |st_addr[1:0];
      end
      default: begin
        fault = 1'b1;
      end
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (st_valid) begin
            if (fault) begin
              st_err <= 1'b1;
            end else begin
              mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= lane_data;
              mem_be    <= lane_be;
              mem_req   <= 1'b1;
              cnt       <= '0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_be  <= 4'b0000;
            st_done <= 1'b1;
            state   <= IDLE;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            mem_be  <= 4'b0000;
            st_err  <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
